systolic_output_deskew: RTL and testbench

Collects results leaving the bottom edge of the 4x4 systolic array, where column c's results emerge c cycles after column 0's. It removes that diagonal skew and packs each aligned result row into one 96-bit word. Rows are buffered in a small FIFO and handed to the host/ARM-side datapath over a valid/ready stream. It also gives the array controller a back-pressure hint so it can stall the array's en before rows are lost.

---
 rtl/systolic_output_deskew.sv | 123 ++++++++++++
 tb/tb_systolic_output_deskew.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_deskew.sv
// Removes the diagonal skew of the 4x4 systolic array bottom edge and buffers aligned rows in a FIFO.
// Optional build macro DESKEW_RELU_EN clamps negative column values to zero before buffering.
module systolic_output_deskew #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THRESH  = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DATA_W-1:0]             psum_in_0,
  input  logic [DATA_W-1:0]             psum_in_1,
  input  logic [DATA_W-1:0]             psum_in_2,
  input  logic [DATA_W-1:0]             psum_in_3,
  input  logic                          col0_valid,
  output logic [4*DATA_W-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          almost_full,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);

  logic [2:0][DATA_W-1:0] d0_q;
  logic [1:0][DATA_W-1:0] d1_q;
  logic [DATA_W-1:0]      d2_q;
  logic [2:0]             vld_q;

  logic [FIFO_DEPTH-1:0][4*DATA_W-1:0] mem_q;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;

  logic                row_wr, full, push, pop, drop;
  logic [4*DATA_W-1:0] row_raw, row_wdata;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

  // Column c is delayed (3 - c) en-cycles so all four line up with column 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      vld_q <= '0;
    end else if (en) begin
      d0_q  <= {d0_q[1], d0_q[0], psum_in_0};
      d1_q  <= {d1_q[0], psum_in_1};
      d2_q  <= psum_in_2;
      vld_q <= {vld_q[1:0], col0_valid};
    end
  end

  assign row_wr  = en & vld_q[2];
  assign row_raw = {psum_in_3, d2_q, d1_q[1], d0_q[2]};

`ifdef DESKEW_RELU_EN
  assign row_wdata = {relu(row_raw[4*DATA_W-1:3*DATA_W]), relu(row_raw[3*DATA_W-1:2*DATA_W]),
                      relu(row_raw[2*DATA_W-1:DATA_W]), relu(row_raw[DATA_W-1:0])};
`else
  assign row_wdata = row_raw;
`endif

  assign out_valid = (count_q != '0);
  assign full      = (count_q == DepthC);
  assign pop       = out_valid & out_ready;
  // A simultaneous pop frees the slot, so a write at full is still accepted.
  assign push      = row_wr & (~full | pop);
  assign drop      = row_wr & full & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    af_d  = (count_d >= AfC);
    ovf_d = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= row_wdata;
  end

  assign out_data    = out_valid ? mem_q[rptr_q] : '0;
  assign count       = count_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Scoreboard bench for systolic_output_deskew: directed rows, expected rows queued, monitor compares.
module tb_systolic_output_deskew;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] psum_in_0, psum_in_1, psum_in_2, psum_in_3;
  logic          col0_valid;
  logic [4*DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    count;
  logic          almost_full;
  logic          overflow;
  logic          clear_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4*DW-1:0] sb[$];

  systolic_output_deskew #(.DATA_W(DW), .FIFO_DEPTH(8), .AF_THRESH(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .psum_in_0      (psum_in_0),
    .psum_in_1      (psum_in_1),
    .psum_in_2      (psum_in_2),
    .psum_in_3      (psum_in_3),
    .col0_valid     (col0_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic logic [4*DW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [DW-1:0] a, b, c, d;
    a = DW'(c0); b = DW'(c1); c = DW'(c2); d = DW'(c3);
    return {d, c, b, a};
  endfunction

  function automatic logic [DW-1:0] sval(input int r, input int nrows, input int base);
    return (r >= 0 && r < nrows) ? DW'(base + r) : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle k of a back-to-back stream: row r hits column c in cycle r + c.
  task automatic drive_stream(input int k, input int nrows, input int base);
    en         = 1'b1;
    col0_valid = (k < nrows);
    psum_in_0  = sval(k, nrows, base);
    psum_in_1  = sval(k - 1, nrows, base);
    psum_in_2  = sval(k - 2, nrows, base);
    psum_in_3  = sval(k - 3, nrows, base);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) tick();
    check("drain_done", {95'd0, out_valid}, '0);
    check("sb_empty", 96'(sb.size()), '0);
    check("drain_count", {92'd0, count}, '0);
    out_ready = 1'b0;
  endtask

  // Monitor: every accepted beat must match the queue head; idle output must be zero.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got %h, required no row", out_data);
      end else begin
        check("row_data", out_data, sb.pop_front());
      end
    end else if (!out_valid) begin
      check("idle_data_zero", out_data, '0);
    end
  end

  initial begin
    int w;
    rst_n = 1'b1; en = 1'b0; col0_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
    psum_in_0 = '0; psum_in_1 = '0; psum_in_2 = '0; psum_in_3 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {95'd0, out_valid}, '0);
    check("rst_count", {92'd0, count}, '0);
    check("rst_af", {95'd0, almost_full}, '0);
    check("rst_ovf", {95'd0, overflow}, '0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();

    // Test 1: single skewed row, out_valid only in cycle 4.
`ifdef DESKEW_RELU_EN
    sb.push_back(pack4(10, 0, 30, 0));
`else
    sb.push_back(pack4(10, -20, 30, -40));
`endif
    out_ready = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      col0_valid = (k == 0);
      if (k == 0) psum_in_0 = DW'(10);
      if (k == 1) psum_in_1 = DW'(-20);
      if (k == 2) psum_in_2 = DW'(30);
      if (k == 3) psum_in_3 = DW'(-40);
      check("t1_valid_timing", {95'd0, out_valid}, {95'd0, k == 4});
      tick();
    end
    check("t1_count", {92'd0, count}, '0);

    // Test 2: same row with en low in cycles 2..4, out_valid only in cycle 7.
    sb.push_back(pack4(10, -20, 30, -40));
    psum_in_0 = '0; psum_in_1 = '0; psum_in_2 = '0; psum_in_3 = '0;
    for (int k = 0; k < 10; k++) begin
      en         = !(k >= 2 && k <= 4);
      col0_valid = (k == 0);
      if (k == 0) psum_in_0 = DW'(10);
      if (k == 1) psum_in_1 = DW'(-20);
      if (k == 2) psum_in_2 = DW'(30);
      if (k == 3) psum_in_3 = DW'(-40);
      check("t2_valid_timing", {95'd0, out_valid}, {95'd0, k == 7});
      tick();
    end
    check("t2_count", {92'd0, count}, '0);
    en = 1'b1;

    // Test 3: nine rows with no reader; row 9 is dropped.
    out_ready = 1'b0;
    for (int r = 1; r <= 8; r++) sb.push_back(pack4(r, r, r, r));
    for (int k = 0; k < 13; k++) begin
      drive_stream(k, 9, 1);
      tick();
      w = (k < 3) ? 0 : ((k - 2 > 8) ? 8 : k - 2);
      check("t3_count", {92'd0, count}, 96'(w));
      check("t3_af", {95'd0, almost_full}, {95'd0, w >= 6});
    end
    check("t3_ovf_set", {95'd0, overflow}, 96'd1);
    drain();
    check("t3_ovf_sticky", {95'd0, overflow}, 96'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t3_ovf_clear", {95'd0, overflow}, '0);

    // Test 4: ninth row written on the same edge as a pop while full.
    for (int r = 11; r <= 19; r++) sb.push_back(pack4(r, r, r, r));
    for (int k = 0; k < 13; k++) begin
      out_ready = (k == 11);
      drive_stream(k, 9, 11);
      tick();
      if (k == 10) check("t4_full", {92'd0, count}, 96'd8);
    end
    out_ready = 1'b0;
    check("t4_count", {92'd0, count}, 96'd8);
    check("t4_ovf", {95'd0, overflow}, '0);
    drain();

    // Test 5: reset with three rows buffered and two in flight.
    for (int k = 0; k < 6; k++) begin
      drive_stream(k, 5, 30);
      tick();
    end
    check("t5_pre_count", {92'd0, count}, 96'd3);
    drive_stream(6, 5, 30);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {95'd0, out_valid}, '0);
    check("t5_rst_data", out_data, '0);
    check("t5_rst_count", {92'd0, count}, '0);
    check("t5_rst_af", {95'd0, almost_full}, '0);
    check("t5_rst_ovf", {95'd0, overflow}, '0);
    tick();
    #2 rst_n = 1'b1;
    col0_valid = 1'b0;
    out_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5_no_stale", {95'd0, out_valid}, '0);
    end
    check("t5_sb_empty", 96'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
